// File: rtl/reduction_mux_pipe_if.sv
// Handshake bundle for reduction_mux_pipe: upstream beat,
// downstream beat and error-counter controls.
interface reduction_mux_pipe_if #(
  parameter int W       = 16,
  parameter int NUM_IN  = 12,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic                     i_valid;
  logic                     o_ready;
  logic [NUM_IN*W-1:0]      i_data;
  logic [NUM_OUT*SEL_W-1:0] i_sel;
  logic [NUM_OUT-1:0]       i_en;
  logic                     i_err_clr;
  logic                     o_valid;
  logic                     i_ready;
  logic [NUM_OUT*W-1:0]     o_data;
  logic [NUM_OUT-1:0]       o_sel_err;
  logic [CNT_W-1:0]         o_err_cnt;

  modport slave (
    input  i_valid, i_data, i_sel, i_en,
    input  i_err_clr, i_ready,
    output o_ready, o_valid, o_data,
    output o_sel_err, o_err_cnt
  );

  modport master (
    output i_valid, i_data, i_sel, i_en,
    output i_err_clr, i_ready,
    input  o_ready, o_valid, o_data,
    input  o_sel_err, o_err_cnt
  );
endinterface

// File: rtl/reduction_mux_pipe.sv
// Grouped per-lane select mux feeding a 2-entry output FIFO,
// with a saturating count of beats carrying select errors.
module reduction_mux_pipe #(
  parameter int W       = 16,
  parameter int NUM_IN  = 12,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  reduction_mux_pipe_if.slave bus
);
  localparam int GRP = NUM_IN / NUM_OUT;
  localparam int DW  = NUM_OUT * W;

  logic [DW-1:0]      mux_data;
  logic [NUM_OUT-1:0] mux_err;

  logic [1:0]         count;
  logic [DW-1:0]      head_data;
  logic [NUM_OUT-1:0] head_err;
  logic [DW-1:0]      tail_data;
  logic [NUM_OUT-1:0] tail_err;
  logic [CNT_W-1:0]   err_cnt;

  logic push;
  logic pop;

  // An enabled lane flags unless some in-range select matches.
  always_comb begin
    mux_data = '0;
    mux_err  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.i_en[k]) begin
        mux_err[k] = 1'b1;
        for (int g = 0; g < GRP; g++) begin
          if (bus.i_sel[k*SEL_W +: SEL_W] == SEL_W'(g)) begin
            mux_data[k*W +: W] = bus.i_data[(k*GRP+g)*W +: W];
            mux_err[k]         = 1'b0;
          end
        end
      end
    end
  end

  assign bus.o_ready = (count != 2'd2);
  assign bus.o_valid = (count != 2'd0);
  assign push = bus.i_valid & bus.o_ready;
  assign pop  = bus.o_valid & bus.i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= '0;
      head_err  <= '0;
      tail_data <= '0;
      tail_err  <= '0;
    end else begin
      unique case (1'b1)
        (push && !pop): count <= count + 2'd1;
        (pop && !push): count <= count - 2'd1;
        default: ;
      endcase
      // Head keeps the popped beat when the FIFO drains.
      if (push && (count == 2'd0 ||
                   (count == 2'd1 && pop))) begin
        head_data <= mux_data;
        head_err  <= mux_err;
      end else if (pop && count == 2'd2) begin
        head_data <= tail_data;
        head_err  <= tail_err;
      end
      if (push && count == 2'd1 && !pop) begin
        tail_data <= mux_data;
        tail_err  <= mux_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (bus.i_err_clr) begin
      err_cnt <= '0;
    end else if (push && (|mux_err) &&
                 err_cnt != {CNT_W{1'b1}}) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.o_data    = head_data;
  assign bus.o_sel_err = head_err;
  assign bus.o_err_cnt = err_cnt;
endmodule
